dmem_latency_model: RTL
=======================

# dmem_latency_model

Parametrised successor to the pipeline's data-memory model: word-addressed storage with byte/half/word access, a configurable fixed response latency, and a BUSY/DONE/ERROR response code. It sits on the pipeline's `o_mem_req_*` / `i_mem_res_*` port group in system benches. It lets stall, load-use and fault paths be exercised against a memory that does not answer in one cycle.

## Interface
Parameters:
- `WORD_COUNT`, 256: number of `WORD_W`-bit words stored; any value ≥ 1.
- `LATENCY`, 2: cycles from request acceptance to the DONE/ERROR response; ≥ 1.
- `ADDR_W`, `` `ADDR_W ``: byte-address width.
- `WORD_W`, 32: data width; fixed at 32 for the lane logic.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req_en`  in  1  request strobe.
- `i_req_addr`  in  `ADDR_W`  byte address.
- `i_req_wr_data`  in  32  write data, right-justified.
- `i_req_wr_en`  in  1  1 = store, 0 = load.
- `i_req_count`  in  `MEM_COUNT_W`  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- `o_res_rd_data`  out  32  load result, right-justified and zero-extended.
- `o_res_code`  out  2  0 IDLE, 1 BUSY, 2 DONE, 3 ERROR. These are added to mem_codes.vh as `MEM_CODE_IDLE/BUSY/DONE/ERROR`.

## Operation
- FSM states:
  - IDLE: code IDLE.
  - WAIT: code BUSY.
  - RESP: code DONE or ERROR.
- Acceptance: a request is accepted on an edge where `i_req_en=1` and the state is IDLE or RESP. On acceptance, addr, wr_data, wr_en and count are latched and the latency counter is loaded with `LATENCY-1`.
- Transitions:
  - Accept with `LATENCY=1` goes straight to RESP.
  - Otherwise accept goes to WAIT. The counter decrements each cycle in WAIT, and WAIT goes to RESP when the counter reaches 0.
  - RESP lasts exactly one cycle. It goes to IDLE, or to WAIT/RESP if a new request is accepted in that cycle.
- Inputs are ignored in WAIT; no queueing.
- Error check at acceptance, on latched values:
  - count = 3 is an error.
  - Half access with addr[0]≠0 is an error.
  - Word access with addr[1:0]≠0 is an error.
  - Out-of-range word index (addr ≥ 4·WORD_COUNT) is an error when range checking is enabled (see Configuration).
  - An erroring request produces ERROR in RESP. Memory is untouched and `o_res_rd_data` is unchanged.
- Store commit: on the edge entering RESP, write only the addressed lanes. Byte goes to lane addr[1:0] from wr_data[7:0]; half goes to lanes addr[1]·2+{0,1} from wr_data[15:0]; word goes to all lanes. Little-endian.
- Load: on the edge entering RESP, `o_res_rd_data` is set to the addressed lanes shifted to bit 0, upper bits zero. It holds until the next successful load. Stores do not change it.
- A load to the address of a store that completed earlier returns the stored data; there is no ordering hazard, because one request is in flight at most.

## Timing
- Reset values: state IDLE, `o_res_code`=0, `o_res_rd_data`=0, counter 0, all memory words 0.
- A request accepted at edge k gives BUSY on edges k+1 … k+LATENCY-1, then DONE/ERROR after edge k+LATENCY, valid for one cycle.
- Back-to-back requests accepted in the RESP cycle give a throughput of one request per LATENCY cycles.
- Reset asserted in WAIT or RESP aborts the in-flight request: no store commit, code IDLE next cycle. Reset has priority over acceptance.
- Outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined: out-of-range addresses give ERROR with no memory side effects.
- Not defined: the word index wraps modulo WORD_COUNT (addr[ADDR_W-1:2] mod WORD_COUNT) and never errors on range. Alignment and count errors still apply.

## Test plan
- Reset, then LATENCY=3, word store 0xDEADBEEF to 0x8: code BUSY for 2 cycles, then DONE for 1 cycle, then IDLE. A following word load from 0x8 returns 0xDEADBEEF.
- Byte stores 0x11/0x22/0x33/0x44 to 0x10..0x13, then word load from 0x10 returns 0x44332211. Half load from 0x12 returns 0x00004433.
- Misaligned requests (half at 0x1, word at 0x2) and count=3: each gives ERROR, and a word load from 0x0 then still returns 0.
- Address 4·WORD_COUNT: with `DMEM_RANGE_CHECK_EN` it gives ERROR; without it, a store aliases to word 0, and a load from 0x0 returns the stored value.
- Back-to-back: LATENCY=1, requests on consecutive cycles give DONE every cycle. LATENCY=2 with a new request in the RESP cycle gives BUSY/DONE alternating and no lost request. `i_req_en` pulsed during WAIT is ignored.
- Reset asserted in the WAIT state of a word store 0x12345678 to 0x4: code IDLE next cycle, and a later load from 0x4 returns 0.

Source files
------------

// File: rtl/dmem_latency_model.sv
// dmem_latency_model: word-addressed data memory with byte/half/word access,
// a fixed response latency and a BUSY/DONE/ERROR response code.
// Optional feature macro: DMEM_RANGE_CHECK_EN. When it is defined, byte
// addresses at or beyond 4*WORD_COUNT answer ERROR. Otherwise the word index
// wraps modulo WORD_COUNT.

`ifndef ADDR_W
`define ADDR_W 32
`endif

`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif

`ifndef MEM_CODE_IDLE
`define MEM_CODE_IDLE  2'd0
`define MEM_CODE_BUSY  2'd1
`define MEM_CODE_DONE  2'd2
`define MEM_CODE_ERROR 2'd3
`endif

module dmem_latency_model #(
  parameter int WORD_COUNT = 256,
  parameter int LATENCY    = 2,
  parameter int ADDR_W     = `ADDR_W,
  parameter int WORD_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_en,
  input  logic [ADDR_W-1:0]       i_req_addr,
  input  logic [WORD_W-1:0]       i_req_wr_data,
  input  logic                    i_req_wr_en,
  input  logic [`MEM_COUNT_W-1:0] i_req_count,
  output logic [WORD_W-1:0]       o_res_rd_data,
  output logic [1:0]              o_res_code
);

  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SZ_W  = `MEM_COUNT_W;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [SZ_W-1:0] SZ_BYTE = SZ_W'(0);
  localparam logic [SZ_W-1:0] SZ_HALF = SZ_W'(1);
  localparam logic [SZ_W-1:0] SZ_WORD = SZ_W'(2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wr_data;
  logic              lat_wr_en;
  logic [SZ_W-1:0]   lat_count;
  logic              lat_err;

  logic [WORD_W-1:0] mem [WORD_COUNT];

  logic              accept;
  logic              enter_resp;
  logic              req_err;
  logic [ADDR_W-1:0] src_addr;
  logic [WORD_W-1:0] src_wr_data;
  logic              src_wr_en;
  logic [SZ_W-1:0]   src_count;
  logic              src_err;
  logic [IDX_W-1:0]  src_idx;
  logic [WORD_W-1:0] mem_word;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_lanes;
  logic [3:0]        lane_en;

  // Size/alignment legality of a request, plus the optional range check.
  function automatic logic access_error(input logic [ADDR_W-1:0] addr,
                                        input logic [SZ_W-1:0]   count);
    logic err;
    err = 1'b0;
    if (count == SZ_HALF)
      err = addr[0];
    else if (count == SZ_WORD)
      err = (addr[1:0] != 2'b00);
    else if (count != SZ_BYTE)
      err = 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
    if (64'(addr) >= (64'(WORD_COUNT) * 64'd4))
      err = 1'b1;
`endif
    return err;
  endfunction

  // Word index taken modulo WORD_COUNT; in range-checked builds an erroring
  // address never reaches memory, so the wrap is harmless there.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    logic [63:0] wa;
    wa = 64'(addr[ADDR_W-1:2]);
    return IDX_W'(wa % 64'(WORD_COUNT));
  endfunction

  // Request acceptance, RESP entry and lane steering for the commit edge.
  // With LATENCY=1 the commit happens on the accepting edge, so the live
  // inputs are used; otherwise the values latched at acceptance are used.
  always_comb begin
    accept     = i_req_en && ((state == ST_IDLE) || (state == ST_RESP));
    enter_resp = ((state == ST_WAIT) && (cnt == CNT_LAST)) ||
                 (accept && (LATENCY == 1));
    req_err    = access_error(i_req_addr, i_req_count);

    if (state == ST_WAIT) begin
      src_addr    = lat_addr;
      src_wr_data = lat_wr_data;
      src_wr_en   = lat_wr_en;
      src_count   = lat_count;
      src_err     = lat_err;
    end else begin
      src_addr    = i_req_addr;
      src_wr_data = i_req_wr_data;
      src_wr_en   = i_req_wr_en;
      src_count   = i_req_count;
      src_err     = req_err;
    end

    src_idx  = word_index(src_addr);
    mem_word = mem[src_idx];
    shifted  = mem_word >> {src_addr[1:0], 3'b000};

    if (src_count == SZ_BYTE) begin
      lane_en  = 4'b0001 << src_addr[1:0];
      wr_word  = {4{src_wr_data[7:0]}};
      rd_lanes = {24'd0, shifted[7:0]};
    end else if (src_count == SZ_HALF) begin
      lane_en  = src_addr[1] ? 4'b1100 : 4'b0011;
      wr_word  = {2{src_wr_data[15:0]}};
      rd_lanes = {16'd0, shifted[15:0]};
    end else begin
      lane_en  = 4'b1111;
      wr_word  = src_wr_data;
      rd_lanes = mem_word;
    end
  end

  // Control FSM: latches a request, counts down the latency, holds RESP one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_wr_data <= '0;
      lat_wr_en   <= 1'b0;
      lat_count   <= '0;
      lat_err     <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_LAST)
            state <= ST_RESP;
        end
        default: begin
          if (accept) begin
            lat_addr    <= i_req_addr;
            lat_wr_data <= i_req_wr_data;
            lat_wr_en   <= i_req_wr_en;
            lat_count   <= i_req_count;
            lat_err     <= req_err;
            cnt         <= CNT_INIT;
            state       <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Datapath: commit stores or capture load data on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_res_rd_data <= '0;
      for (int i = 0; i < WORD_COUNT; i++)
        mem[i] <= '0;
    end else if (enter_resp && !src_err) begin
      if (src_wr_en) begin
        for (int l = 0; l < 4; l++)
          if (lane_en[l])
            mem[src_idx][8*l +: 8] <= wr_word[8*l +: 8];
      end else begin
        o_res_rd_data <= rd_lanes;
      end
    end
  end

  // Response code decoded purely from registered state.
  always_comb begin
    o_res_code = `MEM_CODE_IDLE;
    if (state == ST_WAIT)
      o_res_code = `MEM_CODE_BUSY;
    else if (state == ST_RESP)
      o_res_code = lat_err ? `MEM_CODE_ERROR : `MEM_CODE_DONE;
  end

endmodule
